timer_bank: RTL and testbench

//  N-channel programmable timer / tick generator; generalised successor of the single divide-by-M counter.
//  Per channel: runtime-loadable limit, up/down direction, periodic or one-shot mode.

---
 rtl/timer_pkg.sv | 23 ++
 rtl/timer_bank_if.sv | 28 ++
 rtl/timer_channel.sv | 96 +++++++++
 rtl/timer_bank.sv | 63 ++++++
 tb/tb_timer_bank.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared timer-bank types: channel state encoding, count direction, latched run mode.
package timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // direction and mode are captured together at start and held for the whole run
  typedef struct packed {
    logic dir;
    logic one_shot;
  } mode_t;

endpackage

// File: rtl/timer_bank_if.sv
// Control/status bundle of the timer bank; master drives writes and start/stop, slave is the bank.
interface timer_bank_if #(
  parameter int N_CH = 4,
  parameter int W    = 27,
  parameter int CW   = 2
);
  logic            wr_en;
  logic [CW-1:0]   wr_ch;
  logic [W-1:0]    wr_limit;
  logic [N_CH-1:0] start;
  logic [N_CH-1:0] stop;
  logic [N_CH-1:0] ud;
  logic [N_CH-1:0] oneshot;
  logic [N_CH*W-1:0] count;
  logic [N_CH-1:0] tc_pulse;
  logic [N_CH-1:0] tc_toggle;
  logic [N_CH-1:0] busy;

  modport master (
    output wr_en, wr_ch, wr_limit, start, stop, ud, oneshot,
    input  count, tc_pulse, tc_toggle, busy
  );

  modport slave (
    input  wr_en, wr_ch, wr_limit, start, stop, ud, oneshot,
    output count, tc_pulse, tc_toggle, busy
  );
endinterface

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, up/down count, shadow and active limit, terminal pulse/toggle.
// Count changes one tick after entering RUN; tc_pulse is registered with the wrap; no backpressure.
module timer_channel
  import timer_pkg::*;
#(
  parameter int W = 27
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         wr,
  input  logic [W-1:0] wr_limit,
  input  logic         start,
  input  logic         stop,
  input  logic         ud,
  input  logic         oneshot,
  output logic [W-1:0] count,
  output logic         tc_pulse,
  output logic         tc_toggle,
  output logic         busy
);

  state_e       state_q, state_d;
  mode_t        mode_q, mode_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] lim_q, lim_d;
  logic [W-1:0] shd_q, shd_d;
  logic         tcp_q, tcp_d;
  logic         tgl_q, tgl_d;
  logic         wrap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      cnt_q   <= '0;
      lim_q   <= '0;
      shd_q   <= '0;
      tcp_q   <= 1'b0;
      tgl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      shd_q   <= shd_d;
      tcp_q   <= tcp_d;
      tgl_q   <= tgl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    tcp_d   = 1'b0;
    tgl_d   = tgl_q;
    // a write coinciding with a wrap only reaches the shadow; the wrap takes the old shadow
    shd_d   = wr ? wr_limit : shd_q;
    wrap    = (mode_q.dir == DIR_UP) ? (cnt_q == lim_q) : (cnt_q == '0);

    case (state_q)
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (wrap) begin
            // reload from the shadow so the new period already respects the new limit
            cnt_d = (mode_q.dir == DIR_UP) ? '0 : shd_q;
            lim_d = shd_q;
            tcp_d = 1'b1;
            tgl_d = ~tgl_q;
            if (mode_q.one_shot) state_d = S_DONE;
          end else begin
            cnt_d = (mode_q.dir == DIR_UP) ? cnt_q + W'(1) : cnt_q - W'(1);
          end
        end
      end
      default: begin
        if (start && !stop) begin
          state_d = S_RUN;
          mode_d  = '{dir: ud, one_shot: oneshot};
          lim_d   = shd_q;
          cnt_d   = (ud == DIR_UP) ? '0 : shd_q;
        end
      end
    endcase
  end

  assign count     = cnt_q;
  assign tc_pulse  = tcp_q;
  assign tc_toggle = tgl_q;
  assign busy      = (state_q == S_RUN);

endmodule

// File: rtl/timer_bank.sv
// N-channel timer bank: limit-write decode, optional shared prescaler (TIMER_PRESCALER_EN), channel array.
// Outputs registered per channel; no backpressure, start/stop/write are single-cycle strobes.
module timer_bank
  import timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int W       = 27,
  parameter int CW      = 2,
  parameter int PRE_DIV = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  timer_bank_if.slave  bus
);

  if (PRE_DIV < 1 || (1 << CW) < N_CH) begin : g_param_check
    $error("timer_bank: PRE_DIV must be >= 1 and 2**CW must cover N_CH");
  end

  logic tick;

`ifdef TIMER_PRESCALER_EN
  logic [W-1:0] pre_q;

  // free-running from reset, shared by every channel regardless of their states
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   pre_q <= '0;
    else if (tick)  pre_q <= '0;
    else            pre_q <= pre_q + W'(1);
  end

  assign tick = (pre_q == W'(PRE_DIV - 1));
`else
  assign tick = 1'b1;
`endif

  logic [N_CH*W-1:0] count_flat;
  logic [N_CH-1:0]   tcp_vec, tgl_vec, busy_vec;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    timer_channel #(.W(W)) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .tick      (tick),
      .wr        (bus.wr_en && (bus.wr_ch == CW'(c))),
      .wr_limit  (bus.wr_limit),
      .start     (bus.start[c]),
      .stop      (bus.stop[c]),
      .ud        (bus.ud[c]),
      .oneshot   (bus.oneshot[c]),
      .count     (count_flat[c*W +: W]),
      .tc_pulse  (tcp_vec[c]),
      .tc_toggle (tgl_vec[c]),
      .busy      (busy_vec[c])
    );
  end

  assign bus.count     = count_flat;
  assign bus.tc_pulse  = tcp_vec;
  assign bus.tc_toggle = tgl_vec;
  assign bus.busy      = busy_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: phase-based channel model checked every cycle, plus directed literal sequences.
module tb_timer_bank;

  localparam int N_CH = 4;
  localparam int W    = 27;
  localparam int CW   = 2;
`ifdef TIMER_PRESCALER_EN
  localparam int PDIV = 4;
`else
  localparam int PDIV = 1;
`endif

  logic clock = 1'b0;
  logic reset_n;

  timer_bank_if #(.N_CH(N_CH), .W(W), .CW(CW)) bus ();

  timer_bank #(.N_CH(N_CH), .W(W), .CW(CW), .PRE_DIV(PDIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // model: each channel is a position within its current period plus a direction view
  bit          m_run [N_CH];
  bit          m_dn  [N_CH];
  bit          m_os  [N_CH];
  bit          m_tog [N_CH];
  bit          m_pls [N_CH];
  int unsigned m_lim [N_CH];
  int unsigned m_shd [N_CH];
  int unsigned m_pos [N_CH];
  int unsigned m_pre;

  function automatic longint m_count(int c);
    return m_dn[c] ? longint'(m_lim[c] - m_pos[c]) : longint'(m_pos[c]);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pre = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_run[c] = 0; m_dn[c] = 0; m_os[c] = 0; m_tog[c] = 0; m_pls[c] = 0;
        m_lim[c] = 0; m_shd[c] = 0; m_pos[c] = 0;
      end
    end else begin
      bit tk;
      tk = (m_pre == PDIV - 1);
      m_pre = tk ? 0 : m_pre + 1;
      for (int c = 0; c < N_CH; c++) begin
        m_pls[c] = 0;
        if (m_run[c]) begin
          if (bus.stop[c]) m_run[c] = 0;
          else if (tk) begin
            if (m_pos[c] == m_lim[c]) begin
              m_pos[c] = 0;
              m_lim[c] = m_shd[c];
              m_tog[c] = !m_tog[c];
              m_pls[c] = 1;
              if (m_os[c]) m_run[c] = 0;
            end else begin
              m_pos[c] = m_pos[c] + 1;
            end
          end
        end else if (bus.start[c] && !bus.stop[c]) begin
          m_run[c] = 1;
          m_dn[c]  = !bus.ud[c];
          m_os[c]  = bus.oneshot[c];
          m_lim[c] = m_shd[c];
          m_pos[c] = 0;
        end
      end
      if (bus.wr_en && int'(bus.wr_ch) < N_CH) m_shd[bus.wr_ch] = int'(bus.wr_limit);
    end
  end

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint cnt_of(int c);
    return longint'(bus.count[c*W +: W]);
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      for (int c = 0; c < N_CH; c++) begin
        chk($sformatf("model count ch%0d", c), cnt_of(c), m_count(c));
        chk($sformatf("model tc_pulse ch%0d", c), longint'(bus.tc_pulse[c]), longint'(m_pls[c]));
        chk($sformatf("model tc_toggle ch%0d", c), longint'(bus.tc_toggle[c]), longint'(m_tog[c]));
        chk($sformatf("model busy ch%0d", c), longint'(bus.busy[c]), longint'(m_run[c]));
      end
    end
  end

  task automatic wr_lim(int ch, int val);
    bus.wr_en    = 1'b1;
    bus.wr_ch    = CW'(ch);
    bus.wr_limit = W'(val);
    @(negedge clock);
    bus.wr_en    = 1'b0;
  endtask

  task automatic pulse_start(int ch, bit up, bit os);
    bus.ud[ch]      = up;
    bus.oneshot[ch] = os;
    bus.start[ch]   = 1'b1;
    @(negedge clock);
    bus.start[ch]   = 1'b0;
  endtask

  int exp2 [8]  = '{5, 4, 3, 2, 1, 0, 5, 5};
  int exp3 [12] = '{5, 6, 7, 8, 9, 0, 1, 2, 0, 1, 2, 0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_limit = '0;
    bus.start    = '0;
    bus.stop     = '0;
    bus.ud       = '0;
    bus.oneshot  = '0;
    repeat (2) @(negedge clock);
    cmp_en = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      chk("reset count", cnt_of(c), 0);
      chk("reset busy", longint'(bus.busy[c]), 0);
      chk("reset toggle", longint'(bus.tc_toggle[c]), 0);
    end
    reset_n = 1'b1;
    @(negedge clock);

    // 1: up periodic, limit 3
    wr_lim(0, 3);
    pulse_start(0, 1'b1, 1'b0);
`ifndef TIMER_PRESCALER_EN
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      chk("t1 count", cnt_of(0), i % 4);
      chk("t1 pulse", longint'(bus.tc_pulse[0]), (i == 4) ? 1 : 0);
      chk("t1 toggle", longint'(bus.tc_toggle[0]), (i >= 4) ? 1 : 0);
    end
`endif

    // 2: down one-shot, limit 5
    wr_lim(1, 5);
    pulse_start(1, 1'b0, 1'b1);
`ifndef TIMER_PRESCALER_EN
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clock);
      chk("t2 count", cnt_of(1), exp2[i]);
      chk("t2 pulse", longint'(bus.tc_pulse[1]), (i == 6) ? 1 : 0);
      chk("t2 busy", longint'(bus.busy[1]), (i <= 5) ? 1 : 0);
    end
`endif

    // 3: shadow limit rewritten mid-period
    wr_lim(2, 9);
    pulse_start(2, 1'b1, 1'b0);
    for (int k = 0; k < 60 && cnt_of(2) != 4; k++) @(negedge clock);
    chk("t3 reach count 4", cnt_of(2), 4);
    wr_lim(2, 2);
`ifndef TIMER_PRESCALER_EN
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock);
      chk("t3 count", cnt_of(2), exp3[i]);
      chk("t3 pulse", longint'(bus.tc_pulse[2]), (i == 5 || i == 8 || i == 11) ? 1 : 0);
    end
`else
    repeat (30) @(negedge clock);
`endif

    // 4: start+stop together on a running channel, then limit 0
    wr_lim(3, 6);
    pulse_start(3, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    bus.start[3] = 1'b1;
    bus.stop[3]  = 1'b1;
    @(negedge clock);
    bus.start[3] = 1'b0;
    bus.stop[3]  = 1'b0;
    chk("t4 busy after stop", longint'(bus.busy[3]), 0);
    repeat (3) @(negedge clock);
`ifndef TIMER_PRESCALER_EN
    chk("t4 frozen count", cnt_of(3), 2);
`endif
    wr_lim(3, 0);
    pulse_start(3, 1'b1, 1'b0);
`ifndef TIMER_PRESCALER_EN
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      chk("t4 limit0 count", cnt_of(3), 0);
      chk("t4 limit0 pulse", longint'(bus.tc_pulse[3]), (i >= 1) ? 1 : 0);
      chk("t4 limit0 toggle", longint'(bus.tc_toggle[3]), i % 2);
    end
`else
    repeat (10) @(negedge clock);
`endif

    // 5: asynchronous reset while every channel runs
    pulse_start(1, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    chk("t5 all busy", longint'(bus.busy), 15);
    #2 reset_n = 1'b0;
    #1;
    chk("t5 async count", longint'(bus.count), 0);
    chk("t5 async busy", longint'(bus.busy), 0);
    chk("t5 async pulse", longint'(bus.tc_pulse), 0);
    chk("t5 async toggle", longint'(bus.tc_toggle), 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("t5 no pulse after release", longint'(bus.tc_pulse), 0);
      chk("t5 idle after release", longint'(bus.busy), 0);
    end

`ifdef TIMER_PRESCALER_EN
    // 6: prescaled, limit 1 up -> one pulse per 8 clocks
    begin
      int npulse;
      npulse = 0;
      wr_lim(0, 1);
      pulse_start(0, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
        @(negedge clock);
        if (bus.tc_pulse[0]) npulse++;
      end
      chk("t6 pulses in 40 clocks", npulse, 5);
    end
`endif

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
